// File: rtl/ddr_pixel_feeder.sv
// Pixel FIFO plus line FSM that presents registered D0/D1 half-word pairs,
// with a data-enable and a CE for a bank of ODDR2 output cells.
module ddr_pixel_feeder #(
  parameter int                 DATA_W      = 16,
  parameter int                 FIFO_DEPTH  = 4,
  parameter int                 PRIME_LEVEL = 2,
  parameter logic [DATA_W-1:0]  IDLE_WORD   = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_W-1:0]               s_data,
  input  logic                            s_last,
  input  logic                            enable,
  input  logic                            underrun_clr,
  output logic [DATA_W/2-1:0]             d0,
  output logic [DATA_W/2-1:0]             d1,
  output logic                            de,
  output logic                            ce,
  output logic                            line_end,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int H  = DATA_W / 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PRIME_C = CW'(PRIME_LEVEL);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_last;
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count, r_last_cnt;
  logic [H-1:0]      r_d0, r_d1;
  logic              r_de, r_ce, r_line_end, r_underrun;

  logic              w_push, w_pop, w_ur_set;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_last;

  assign s_ready     = ~rst & (r_count < DEPTH_C);
  assign w_push      = s_valid & s_ready;
  assign w_head_data = r_mem[r_rd_ptr];
  assign w_head_last = r_last[r_rd_ptr];

  // Storage needs no reset: only entries below r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]  <= s_data;
      r_last[r_wr_ptr] <= s_last;
    end
  end

  // r_last_cnt tracks buffered line ends so a short line can start unprimed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_last_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_last_cnt <= r_last_cnt + CW'(w_push & s_last) - CW'(w_pop & w_head_last);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_ur_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && ((r_count >= PRIME_C) || (r_last_cnt != '0))) begin
          w_pop = 1'b1;
          if (!w_head_last) w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_head_last) w_state_nxt = S_IDLE;
        end else begin
          w_ur_set = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_d0       <= IDLE_WORD[DATA_W-1:H];
      r_d1       <= IDLE_WORD[H-1:0];
      r_de       <= 1'b0;
      r_ce       <= 1'b0;
      r_line_end <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ce    <= enable;
      if (w_pop) begin
        r_d0       <= w_head_data[DATA_W-1:H];
        r_d1       <= w_head_data[H-1:0];
        r_de       <= 1'b1;
        r_line_end <= w_head_last;
      end else begin
        r_d0       <= IDLE_WORD[DATA_W-1:H];
        r_d1       <= IDLE_WORD[H-1:0];
        r_de       <= 1'b0;
        r_line_end <= 1'b0;
      end
      if (w_ur_set)          r_underrun <= 1'b1;
      else if (underrun_clr) r_underrun <= 1'b0;
    end
  end

  assign d0         = r_d0;
  assign d1         = r_d1;
  assign de         = r_de;
  assign ce         = r_ce;
  assign line_end   = r_line_end;
  assign underrun   = r_underrun;
  assign fifo_level = r_count;

endmodule

// File: tb/tb_ddr_pixel_feeder.sv
// Bench for ddr_pixel_feeder: directed scenarios plus a random phase, compared
// each cycle against a queue-based model of the pixel stream.
module tb_ddr_pixel_feeder;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int PRIME  = 2;
  localparam logic [DATA_W-1:0] IDLE_W = 16'h5AA5;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic        enable;
  logic        underrun_clr;
  logic [7:0]  d0, d1;
  logic        de, ce, line_end, underrun;
  logic [2:0]  fifo_level;

  ddr_pixel_feeder #(
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (DEPTH),
    .PRIME_LEVEL (PRIME),
    .IDLE_WORD   (IDLE_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .enable       (enable),
    .underrun_clr (underrun_clr),
    .d0           (d0),
    .d1           (d1),
    .de           (de),
    .ce           (ce),
    .line_end     (line_end),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: FIFO contents as a queue of {last, pixel}, plus whether a line is open.
  logic [16:0] mq[$];
  bit          m_in_line;
  logic [15:0] idle_w;
  logic [7:0]  e_d0, e_d1;
  logic        e_de, e_ce, e_le, e_ur;

  int n_checks = 0;
  int n_pass   = 0;
  int run      = 0;
  int max_run  = 0;
  int max_lvl  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all();
    check("d0", 32'(d0), 32'(e_d0));
    check("d1", 32'(d1), 32'(e_d1));
    check("de", 32'(de), 32'(e_de));
    check("ce", 32'(ce), 32'(e_ce));
    check("line_end", 32'(line_end), 32'(e_le));
    check("underrun", 32'(underrun), 32'(e_ur));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("s_ready", 32'(s_ready), 32'(!rst && (mq.size() < DEPTH)));
  endtask

  task automatic model_reset();
    mq.delete();
    m_in_line = 1'b0;
    e_d0 = idle_w[15:8];
    e_d1 = idle_w[7:0];
    e_de = 1'b0;
    e_ce = 1'b0;
    e_le = 1'b0;
    e_ur = 1'b0;
  endtask

  // One clock: decide from the rules what happens at the edge, then check outputs.
  task automatic step();
    bit          push, pop, set_ur, has_last;
    logic [16:0] head;
    push     = s_valid && (mq.size() < DEPTH);
    pop      = 1'b0;
    set_ur   = 1'b0;
    has_last = 1'b0;
    foreach (mq[i]) if (mq[i][16]) has_last = 1'b1;
    if (!m_in_line)          pop = enable && ((mq.size() >= PRIME) || has_last);
    else if (mq.size() > 0)  pop = 1'b1;
    else                     set_ur = 1'b1;
    @(posedge clk);
    if (pop) begin
      head      = mq.pop_front();
      e_d0      = head[15:8];
      e_d1      = head[7:0];
      e_de      = 1'b1;
      e_le      = head[16];
      m_in_line = !head[16];
    end else begin
      e_d0 = idle_w[15:8];
      e_d1 = idle_w[7:0];
      e_de = 1'b0;
      e_le = 1'b0;
    end
    if (push) mq.push_back({s_last, s_data});
    if (set_ur)            e_ur = 1'b1;
    else if (underrun_clr) e_ur = 1'b0;
    e_ce = enable;
    #1;
    check_all();
    if (de) run++; else run = 0;
    if (run > max_run) max_run = run;
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
  endtask

  task automatic push_px(input logic [15:0] px, input logic last);
    s_valid = 1'b1;
    s_data  = px;
    s_last  = last;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  logic [15:0] pat [4];

  initial begin
    idle_w = IDLE_W;
    pat[0] = 16'hA1B2; pat[1] = 16'hC3D4; pat[2] = 16'hE5F6; pat[3] = 16'h0718;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    enable = 1'b0; underrun_clr = 1'b0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;
    #1;
    check("s_ready_after_rst", 32'(s_ready), 32'd1);

    // Basic four-pixel line.
    enable = 1'b1;
    for (int i = 0; i < 4; i++) push_px(pat[i], i == 3);
    for (int i = 0; i < 4; i++) step();

    // Fill with output held off, then release.
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = 16'($urandom);
      s_last  = (i == 3);
      step();
    end
    s_valid = 1'b0; s_last = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Single-pixel line starts below the prime level.
    push_px(16'h9C3E, 1'b1);
    for (int i = 0; i < 3; i++) step();

    // Mid-line gap, clear colliding with set, then clear alone.
    for (int i = 0; i < 3; i++) push_px(16'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) step();
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    push_px(16'($urandom), 1'b1);
    step();
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    step();

    // Reset with three pixels buffered.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push_px(16'($urandom), 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Continuous 64-pixel line.
    run = 0; max_run = 0; max_lvl = 0;
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1;
      s_data  = 16'($urandom);
      s_last  = (i == 63);
      step();
    end
    s_valid = 1'b0; s_last = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("long_line_de_run", 32'(max_run), 32'd64);
    check("long_line_level", 32'(max_lvl <= PRIME), 32'd1);
    check("long_line_no_underrun", 32'(underrun), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      s_valid      = ($urandom_range(0, 3) != 0);
      s_data       = 16'($urandom);
      s_last       = ($urandom_range(0, 5) == 0);
      enable       = ($urandom_range(0, 9) != 0);
      underrun_clr = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
